// File: rtl/boot_loader_if.sv
// Boot-loader bus bundle: boot ROM read port plus instruction RAM req/gnt write port.
// The master modport is the copy engine; the slave modport is the ROM/RAM side.
interface boot_loader_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_ADDR_WIDTH = 16
);
    logic                      rom_en_o;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0]     rom_rdata_i;

    logic                      ram_req_o;
    logic                      ram_we_o;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0]     ram_wdata_o;
    logic [3:0]                ram_be_o;
    logic                      ram_gnt_i;

    modport master (
        output rom_en_o, rom_addr_o,
        input  rom_rdata_i,
        output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
        input  ram_gnt_i
    );

    modport slave (
        input  rom_en_o, rom_addr_o,
        output rom_rdata_i,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
        output ram_gnt_i
    );
endinterface

// File: rtl/boot_loader.sv
// Copies ROM_WORDS boot words from the boot ROM into instruction RAM, then enables core fetch.
// Define BOOT_LOADER_CSUM_EN to add csum_o, a mod-2^32 running sum of every granted write.
module boot_loader #(
    parameter int unsigned ROM_WORDS      = 58,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned RAM_BASE       = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    boot_loader_if.master bus,
    output logic          busy_o,
    output logic          done_o,
    output logic          fetch_en_o
`ifdef BOOT_LOADER_CSUM_EN
    ,
    output logic [31:0]   csum_o
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX = ROM_ADDR_WIDTH'(ROM_WORDS - 1);

    logic [2:0]                state;
    logic [ROM_ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0]     data_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            idx    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (start_i) state <= ST_READ;
                ST_READ:  state <= ST_LATCH;
                ST_LATCH: begin
                    data_q <= bus.rom_rdata_i;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bus.ram_gnt_i) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + ROM_ADDR_WIDTH'(1);
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef BOOT_LOADER_CSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else if (state == ST_WRITE && bus.ram_gnt_i) begin
            csum_q <= csum_q + data_q;
        end
    end

    assign csum_o = csum_q;
`endif

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        bus.rom_en_o    = 1'b0;
        bus.rom_addr_o  = '0;
        bus.ram_req_o   = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_be_o    = 4'h0;
        done_o          = 1'b0;
        case (state)
            ST_READ: begin
                bus.rom_en_o   = 1'b1;
                bus.rom_addr_o = idx;
            end
            ST_WRITE: begin
                bus.ram_req_o   = 1'b1;
                bus.ram_we_o    = 1'b1;
                bus.ram_be_o    = 4'hF;
                bus.ram_addr_o  = RAM_ADDR_WIDTH'(RAM_BASE + (32'(idx) << 2));
                bus.ram_wdata_o = data_q;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
        busy_o     = (state == ST_READ) || (state == ST_LATCH) || (state == ST_WRITE);
        fetch_en_o = done_o;
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: ROM/RAM models, per-word grant stalls and a write scoreboard.
// Build with BOOT_LOADER_CSUM_EN defined to also check the checksum port.
module tb_boot_loader;

    localparam int N        = 58;
    localparam int RAM_BASE = 32'h0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o, done_o, fetch_en_o;
`ifdef BOOT_LOADER_CSUM_EN
    logic [31:0] csum_o;
`endif

    boot_loader_if #(.DATA_WIDTH(32), .ROM_ADDR_WIDTH(10), .RAM_ADDR_WIDTH(16)) bus ();

    boot_loader #(
        .ROM_WORDS(N), .DATA_WIDTH(32), .ROM_ADDR_WIDTH(10),
        .RAM_ADDR_WIDTH(16), .RAM_BASE(RAM_BASE)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fetch_en_o (fetch_en_o)
`ifdef BOOT_LOADER_CSUM_EN
        ,
        .csum_o     (csum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Boot ROM model with one-cycle registered read.
    logic [31:0] rom [0:1023];
    always @(posedge clk_i) if (bus.rom_en_o) bus.rom_rdata_i <= rom[bus.rom_addr_o];

    // Scoreboard state shared with the monitor; the stimulus side only touches it off the negedge.
    int          stall_tab [0:N-1];
    int          wr_ptr, stall_cnt, en_cnt;
    bit          was_stalled;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    // Negedge monitor: chooses ram_gnt_i for the next edge and scores every write it grants.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("we_eq_req", bus.ram_we_o, bus.ram_req_o);
            check("be", bus.ram_be_o, bus.ram_req_o ? 4'hF : 4'h0);
            check("fetch_eq_done", fetch_en_o, done_o);
            if (!bus.rom_en_o) check("rom_addr_idle", bus.rom_addr_o, 0);
            else en_cnt++;
            if (bus.ram_req_o) begin
                if (was_stalled) begin
                    check("stall_addr", bus.ram_addr_o, prev_addr);
                    check("stall_data", bus.ram_wdata_o, prev_data);
                end
                if (wr_ptr >= N) begin
                    check("extra_write", wr_ptr, N - 1);
                    bus.ram_gnt_i = 1'b1;
                end else if (stall_cnt < stall_tab[wr_ptr]) begin
                    bus.ram_gnt_i = 1'b0;
                    stall_cnt++;
                    was_stalled = 1'b1;
                    prev_addr = bus.ram_addr_o;
                    prev_data = bus.ram_wdata_o;
                end else begin
                    bus.ram_gnt_i = 1'b1;
                    check("wr_addr", bus.ram_addr_o, 16'(RAM_BASE + 4 * wr_ptr));
                    check("wr_data", bus.ram_wdata_o, rom[wr_ptr]);
                    wr_ptr++;
                    stall_cnt = 0;
                    was_stalled = 1'b0;
                end
            end else begin
                check("ram_idle", {bus.ram_addr_o, bus.ram_wdata_o}, 0);
                bus.ram_gnt_i = 1'($urandom_range(0, 1));
                was_stalled = 1'b0;
            end
        end
    end

    task automatic clear_sb();
        wr_ptr = 0; stall_cnt = 0; en_cnt = 0; was_stalled = 1'b0;
        for (int i = 0; i < N; i++) stall_tab[i] = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {bus.rom_en_o, bus.ram_req_o, bus.ram_we_o, bus.ram_be_o,
                              busy_o, done_o, fetch_en_o}, 0);
        check({tag, "_addr"}, {bus.rom_addr_o, bus.ram_addr_o}, 0);
        check({tag, "_data"}, bus.ram_wdata_o, 0);
    endtask

    // Asserts reset mid-cycle, checks outputs drop before the next edge, clears the scoreboard.
    task automatic apply_reset(input string tag);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        check_outputs_zero(tag);
        clear_sb();
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = '0;
        for (int i = 0; i < N; i++) s += rom[i];
        return s;
    endfunction

    // Starts a copy at the next edge and returns the edges until done_o is seen.
    task automatic run_copy(input bit keep_start, output int cycles);
        @(negedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1;
        if (!keep_start) start_i = 1'b0;
        cycles = 0;
        while (!done_o && cycles < 5000) begin
            @(posedge clk_i); #1;
            cycles++;
        end
        if (cycles >= 5000) check("done_timeout", 0, 1);
    endtask

    function automatic int total_stalls();
        int t = 0;
        for (int i = 0; i < N; i++) t += stall_tab[i];
        return t;
    endfunction

    int cyc, exp_cyc, en_snap, guard;

    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        bus.ram_gnt_i = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hB007_0000 + i;
        clear_sb();

        // Reset state, then an idle window with start low.
        apply_reset("rst_init");
        repeat (20) @(posedge clk_i);
        #1;
        check("idle_no_rom", en_cnt, 0);
        check("idle_no_ram", wr_ptr, 0);
        check_outputs_zero("idle");

        // Full copy, no grant stalls.
        run_copy(1'b0, cyc);
        check("lat_nostall", cyc, 3 * N);
        check("words_nostall", wr_ptr, N);
        check("done_flags", {done_o, fetch_en_o, busy_o}, 3'b110);
`ifdef BOOT_LOADER_CSUM_EN
        check("csum_b007", csum_o, model_sum());
`endif

        // Random ROM contents with random grant stalls, 5 on word 3.
        apply_reset("rst_stall");
        for (int i = 0; i < N; i++) begin
            rom[i] = $urandom;
            stall_tab[i] = $urandom_range(0, 3);
        end
        stall_tab[3] = 5;
        exp_cyc = 3 * N + total_stalls();
        run_copy(1'b0, cyc);
        check("lat_stall", cyc, exp_cyc);
        check("words_stall", wr_ptr, N);
`ifdef BOOT_LOADER_CSUM_EN
        check("csum_rand", csum_o, model_sum());
`endif

        // start_i held high through and after the copy.
        apply_reset("rst_hold");
        for (int i = 0; i < N; i++) rom[i] = 32'hB007_0000 + i;
        run_copy(1'b1, cyc);
        check("lat_hold", cyc, 3 * N);
        en_snap = en_cnt;
        repeat (20) @(posedge clk_i);
        #1;
        check("hold_words", wr_ptr, N);
        check("hold_no_reread", en_cnt, en_snap);
        check("hold_done", done_o, 1);
        start_i = 1'b0;

        // Reset while word 10 is waiting for grant, then a clean rerun.
        apply_reset("rst_pre_abort");
        stall_tab[10] = 100000;
        @(negedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        guard = 0;
        while (!(wr_ptr == 10 && bus.ram_req_o) && guard < 2000) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("reach_word10", wr_ptr, 10);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_outputs_zero("rst_abort");
        repeat (3) @(posedge clk_i);
        #1 check("abort_no_writes", wr_ptr, 10);
        clear_sb();
        #1 rst_i = 1'b0;
        run_copy(1'b0, cyc);
        check("lat_rerun", cyc, 3 * N);
        check("words_rerun", wr_ptr, N);

`ifdef BOOT_LOADER_CSUM_EN
        // Checksum of words 1..58.
        apply_reset("rst_csum");
        for (int i = 0; i < N; i++) rom[i] = i + 1;
        run_copy(1'b0, cyc);
        check("csum_1711", csum_o, 32'd1711);
        repeat (5) @(posedge clk_i);
        #1 check("csum_held", csum_o, model_sum());
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
